// File: rtl/pipeline_front_regs.sv
// pipeline_front_regs
//   Front-end pipeline register bank of the 5-stage RV32I core: the PC
//   register, the IF/ID register and the ID/EX register, steered by the
//   hazard unit (StallF/StallD/FlushD/Flush_E) and the execute-stage redirect
//   (PCSrc_E/PCTarget_E). Tracks per-stage valid bits and keeps saturating
//   stall/flush event counters.
// Ports
//   clk, rst_n                 rising-edge clock, async active-low reset
//   StallF, StallD             hold PC / hold IF/ID
//   FlushD, Flush_E            bubble IF/ID / bubble ID/EX
//   PCSrc_E, PCTarget_E        fetch redirect and its target
//   Instr_F                    instruction fetched at PC_F
//   PC_F                       fetch address
//   Instr_D, PC_D, PCPlus4_D,  IF/ID contents
//   Valid_D
//   Ctrl_D, RD1_D, RD2_D,      decode-stage values captured into ID/EX
//   ImmExt_D
//   Ctrl_E, RD1_E, RD2_E,      ID/EX contents
//   ImmExt_E, PC_E, PCPlus4_E,
//   Rs1_E, Rs2_E, Rd_E, Valid_E
//   Stall_Cnt, Flush_Cnt       saturating event counters
// All outputs come straight from registers.
module pipeline_front_regs #(
  parameter int unsigned          XLEN     = 32,
  parameter int unsigned          CTRL_W   = 10,
  parameter logic [XLEN-1:0]      RESET_PC = '0,
  parameter logic [31:0]          NOP      = 32'h0000_0013,
  parameter int unsigned          PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              Flush_E,
  input  logic              PCSrc_E,
  input  logic [XLEN-1:0]   PCTarget_E,
  input  logic [31:0]       Instr_F,
  output logic [XLEN-1:0]   PC_F,
  output logic [31:0]       Instr_D,
  output logic [XLEN-1:0]   PC_D,
  output logic [XLEN-1:0]   PCPlus4_D,
  output logic              Valid_D,
  input  logic [CTRL_W-1:0] Ctrl_D,
  input  logic [XLEN-1:0]   RD1_D,
  input  logic [XLEN-1:0]   RD2_D,
  input  logic [XLEN-1:0]   ImmExt_D,
  output logic [CTRL_W-1:0] Ctrl_E,
  output logic [XLEN-1:0]   RD1_E,
  output logic [XLEN-1:0]   RD2_E,
  output logic [XLEN-1:0]   ImmExt_E,
  output logic [XLEN-1:0]   PC_E,
  output logic [XLEN-1:0]   PCPlus4_E,
  output logic [4:0]        Rs1_E,
  output logic [4:0]        Rs2_E,
  output logic [4:0]        Rd_E,
  output logic              Valid_E,
  output logic [PERF_W-1:0] Stall_Cnt,
  output logic [PERF_W-1:0] Flush_Cnt
);

  // Fetch stage
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc_plus4;

  // IF/ID
  logic [31:0]       instr_d_q, instr_d_d;
  logic [XLEN-1:0]   pc_d_q, pc_d_d;
  logic [XLEN-1:0]   pcp4_d_q, pcp4_d_d;
  logic              valid_d_q, valid_d_d;

  // ID/EX
  logic [CTRL_W-1:0] ctrl_e_q, ctrl_e_d;
  logic [XLEN-1:0]   rd1_e_q, rd1_e_d;
  logic [XLEN-1:0]   rd2_e_q, rd2_e_d;
  logic [XLEN-1:0]   imm_e_q, imm_e_d;
  logic [XLEN-1:0]   pc_e_q, pc_e_d;
  logic [XLEN-1:0]   pcp4_e_q, pcp4_e_d;
  logic [4:0]        rs1_e_q, rs1_e_d;
  logic [4:0]        rs2_e_q, rs2_e_d;
  logic [4:0]        rd_e_q, rd_e_d;
  logic              valid_e_q, valid_e_d;

  // Counters
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  assign pc_plus4 = pc_q + XLEN'(4);

  // PC: redirect beats stall; plain increment wraps naturally modulo 2^XLEN.
  always_comb begin
    pc_d = pc_q;
    if (PCSrc_E)      pc_d = PCTarget_E;
    else if (!StallF) pc_d = pc_plus4;
  end

  // IF/ID: flush beats stall.
  always_comb begin
    instr_d_d = instr_d_q;
    pc_d_d    = pc_d_q;
    pcp4_d_d  = pcp4_d_q;
    valid_d_d = valid_d_q;
    if (FlushD) begin
      instr_d_d = NOP;
      pc_d_d    = '0;
      pcp4_d_d  = '0;
      valid_d_d = 1'b0;
    end else if (!StallD) begin
      instr_d_d = Instr_F;
      pc_d_d    = pc_q;
      pcp4_d_d  = pc_plus4;
      valid_d_d = 1'b1;
    end
  end

  // ID/EX: never stalled; a flush inserts an all-zero bubble.
  always_comb begin
    ctrl_e_d  = Ctrl_D;
    rd1_e_d   = RD1_D;
    rd2_e_d   = RD2_D;
    imm_e_d   = ImmExt_D;
    pc_e_d    = pc_d_q;
    pcp4_e_d  = pcp4_d_q;
    rs1_e_d   = instr_d_q[19:15];
    rs2_e_d   = instr_d_q[24:20];
    rd_e_d    = instr_d_q[11:7];
    valid_e_d = valid_d_q;
    if (Flush_E) begin
      ctrl_e_d  = '0;
      rd1_e_d   = '0;
      rd2_e_d   = '0;
      imm_e_d   = '0;
      pc_e_d    = '0;
      pcp4_e_d  = '0;
      rs1_e_d   = '0;
      rs2_e_d   = '0;
      rd_e_d    = '0;
      valid_e_d = 1'b0;
    end
  end

  // Saturating counters; both flush sources share one count per cycle.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    if ((FlushD || Flush_E) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      instr_d_q   <= NOP;
      pc_d_q      <= '0;
      pcp4_d_q    <= '0;
      valid_d_q   <= 1'b0;
      ctrl_e_q    <= '0;
      rd1_e_q     <= '0;
      rd2_e_q     <= '0;
      imm_e_q     <= '0;
      pc_e_q      <= '0;
      pcp4_e_q    <= '0;
      rs1_e_q     <= '0;
      rs2_e_q     <= '0;
      rd_e_q      <= '0;
      valid_e_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      instr_d_q   <= instr_d_d;
      pc_d_q      <= pc_d_d;
      pcp4_d_q    <= pcp4_d_d;
      valid_d_q   <= valid_d_d;
      ctrl_e_q    <= ctrl_e_d;
      rd1_e_q     <= rd1_e_d;
      rd2_e_q     <= rd2_e_d;
      imm_e_q     <= imm_e_d;
      pc_e_q      <= pc_e_d;
      pcp4_e_q    <= pcp4_e_d;
      rs1_e_q     <= rs1_e_d;
      rs2_e_q     <= rs2_e_d;
      rd_e_q      <= rd_e_d;
      valid_e_q   <= valid_e_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PC_F      = pc_q;
  assign Instr_D   = instr_d_q;
  assign PC_D      = pc_d_q;
  assign PCPlus4_D = pcp4_d_q;
  assign Valid_D   = valid_d_q;
  assign Ctrl_E    = ctrl_e_q;
  assign RD1_E     = rd1_e_q;
  assign RD2_E     = rd2_e_q;
  assign ImmExt_E  = imm_e_q;
  assign PC_E      = pc_e_q;
  assign PCPlus4_E = pcp4_e_q;
  assign Rs1_E     = rs1_e_q;
  assign Rs2_E     = rs2_e_q;
  assign Rd_E      = rd_e_q;
  assign Valid_E   = valid_e_q;
  assign Stall_Cnt = stall_cnt_q;
  assign Flush_Cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_front_regs.sv
// Directed bench for pipeline_front_regs (PERF_W=4 so saturation is reachable).
module tb_pipeline_front_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF, StallD, FlushD, Flush_E, PCSrc_E;
  logic [31:0] PCTarget_E, Instr_F;
  logic [31:0] PC_F, Instr_D, PC_D, PCPlus4_D;
  logic        Valid_D;
  logic [9:0]  Ctrl_D, Ctrl_E;
  logic [31:0] RD1_D, RD2_D, ImmExt_D;
  logic [31:0] RD1_E, RD2_E, ImmExt_E, PC_E, PCPlus4_E;
  logic [4:0]  Rs1_E, Rs2_E, Rd_E;
  logic        Valid_E;
  logic [3:0]  Stall_Cnt, Flush_Cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_front_regs #(.PERF_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .Flush_E(Flush_E),
    .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E), .Instr_F(Instr_F),
    .PC_F(PC_F), .Instr_D(Instr_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
    .Valid_D(Valid_D), .Ctrl_D(Ctrl_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
    .ImmExt_D(ImmExt_D), .Ctrl_E(Ctrl_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .ImmExt_E(ImmExt_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E), .Valid_E(Valid_E),
    .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
  );

  typedef struct {
    logic        sF, sD, fD, fE, pcs;
    logic [31:0] tgt, instr;
    logic [9:0]  ctrl;
    logic [31:0] rd1;
    logic [31:0] e_pc, e_iD, e_pcD;
    logic        e_vD;
    logic [9:0]  e_ctrlE;
    logic [31:0] e_rd1E, e_pcE;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic        e_vE;
    logic [3:0]  e_sc, e_fc;
  } vec_t;

  vec_t vecs[12];

  // RD2_D / ImmExt_D are fixed rearrangements of RD1_D (zero maps to zero).
  function automatic logic [31:0] f_rd2(input logic [31:0] v);
    return {v[15:0], v[31:16]};
  endfunction
  function automatic logic [31:0] f_imm(input logic [31:0] v);
    return {v[23:0], v[31:24]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sF, input logic sD, input logic fD, input logic fE,
                       input logic pcs, input logic [31:0] tgt, input logic [31:0] instr,
                       input logic [9:0] ctrl, input logic [31:0] rd1);
    StallF = sF; StallD = sD; FlushD = fD; Flush_E = fE; PCSrc_E = pcs;
    PCTarget_E = tgt; Instr_F = instr; Ctrl_D = ctrl;
    RD1_D = rd1; RD2_D = f_rd2(rd1); ImmExt_D = f_imm(rd1);
  endtask

  initial begin
    //               sF sD fD fE pcs tgt          instr         ctrl    rd1            | PC_F        Instr_D       PC_D        vD  Ctrl_E  RD1_E          PC_E       rs1 rs2 rd  vE sc fc
    vecs[0]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0000_0093, 10'h101, 32'h1111_0000, 32'h4,      32'h0000_0093, 32'h0,      1, 10'h101, 32'h1111_0000, 32'h0,     0, 0, 0,  0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0000_2083, 10'h202, 32'h2222_0000, 32'h8,      32'h0000_2083, 32'h4,      1, 10'h202, 32'h2222_0000, 32'h0,     0, 0, 1,  1, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0041_8F33, 10'h303, 32'h3333_0000, 32'hC,      32'h0041_8F33, 32'h8,      1, 10'h303, 32'h3333_0000, 32'h4,     0, 0, 1,  1, 0, 0};
    // load-use stall: PC and IF/ID hold, bubble into E
    vecs[3]  = '{1, 1, 0, 1, 0, 32'h0,        32'h0000_0513, 10'h3FF, 32'h4444_0000, 32'hC,      32'h0041_8F33, 32'h8,      1, 10'h000, 32'h0,         32'h0,     0, 0, 0,  0, 1, 1};
    vecs[4]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0000_0513, 10'h055, 32'h5555_0000, 32'h10,     32'h0000_0513, 32'hC,      1, 10'h055, 32'h5555_0000, 32'h8,     3, 4, 30, 1, 1, 1};
    // taken branch: redirect, flush D and E
    vecs[5]  = '{0, 0, 1, 1, 1, 32'h100,      32'hDEAD_BEEF, 10'h3FF, 32'h6666_0000, 32'h100,    32'h0000_0013, 32'h0,      0, 10'h000, 32'h0,         32'h0,     0, 0, 0,  0, 1, 2};
    // redirect + flush win over both stalls
    vecs[6]  = '{1, 1, 1, 0, 1, 32'h200,      32'h0000_0093, 10'h0AA, 32'h7777_0000, 32'h200,    32'h0000_0013, 32'h0,      0, 10'h0AA, 32'h7777_0000, 32'h0,     0, 0, 0,  0, 2, 3};
    vecs[7]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0000_0513, 10'h111, 32'h8888_0000, 32'h204,    32'h0000_0513, 32'h200,    1, 10'h111, 32'h8888_0000, 32'h0,     0, 0, 0,  0, 2, 3};
    // StallF alone: PC holds, IF/ID still loads
    vecs[8]  = '{1, 0, 0, 0, 0, 32'h0,        32'h0000_0093, 10'h222, 32'h9999_0000, 32'h204,    32'h0000_0093, 32'h204,    1, 10'h222, 32'h9999_0000, 32'h200,   0, 0, 10, 1, 2, 3};
    // StallD alone: IF/ID holds, PC advances, E re-captures held IF/ID
    vecs[9]  = '{0, 1, 0, 0, 0, 32'h0,        32'h0000_2083, 10'h333, 32'hAAAA_0000, 32'h208,    32'h0000_0093, 32'h204,    1, 10'h333, 32'hAAAA_0000, 32'h204,   0, 0, 1,  1, 3, 3};
    // FlushD alone
    vecs[10] = '{0, 0, 1, 0, 0, 32'h0,        32'h0000_2083, 10'h044, 32'hBBBB_0000, 32'h20C,    32'h0000_0013, 32'h0,      0, 10'h044, 32'hBBBB_0000, 32'h204,   0, 0, 1,  1, 3, 4};
    vecs[11] = '{0, 0, 0, 0, 0, 32'h0,        32'h0000_2083, 10'h000, 32'hCCCC_0000, 32'h210,    32'h0000_2083, 32'h20C,    1, 10'h000, 32'hCCCC_0000, 32'h0,     0, 0, 0,  0, 3, 4};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 10'h0, 32'h0);
    repeat (3) step();

    chk("reset PC_F", PC_F, 32'h0);
    chk("reset Instr_D", Instr_D, 32'h0000_0013);
    chk("reset Valid_D", {31'b0, Valid_D}, 32'h0);
    chk("reset Valid_E", {31'b0, Valid_E}, 32'h0);
    chk("reset Ctrl_E", {22'b0, Ctrl_E}, 32'h0);
    chk("reset Stall_Cnt", {28'b0, Stall_Cnt}, 32'h0);
    chk("reset Flush_Cnt", {28'b0, Flush_Cnt}, 32'h0);

    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].sF, vecs[i].sD, vecs[i].fD, vecs[i].fE, vecs[i].pcs,
            vecs[i].tgt, vecs[i].instr, vecs[i].ctrl, vecs[i].rd1);
      step();
      chk($sformatf("v%0d PC_F", i), PC_F, vecs[i].e_pc);
      chk($sformatf("v%0d Instr_D", i), Instr_D, vecs[i].e_iD);
      chk($sformatf("v%0d PC_D", i), PC_D, vecs[i].e_pcD);
      chk($sformatf("v%0d PCPlus4_D", i), PCPlus4_D,
          vecs[i].e_vD ? vecs[i].e_pcD + 32'd4 : 32'h0);
      chk($sformatf("v%0d Valid_D", i), {31'b0, Valid_D}, {31'b0, vecs[i].e_vD});
      chk($sformatf("v%0d Ctrl_E", i), {22'b0, Ctrl_E}, {22'b0, vecs[i].e_ctrlE});
      chk($sformatf("v%0d RD1_E", i), RD1_E, vecs[i].e_rd1E);
      chk($sformatf("v%0d RD2_E", i), RD2_E, f_rd2(vecs[i].e_rd1E));
      chk($sformatf("v%0d ImmExt_E", i), ImmExt_E, f_imm(vecs[i].e_rd1E));
      chk($sformatf("v%0d PC_E", i), PC_E, vecs[i].e_pcE);
      chk($sformatf("v%0d PCPlus4_E", i), PCPlus4_E,
          vecs[i].e_vE ? vecs[i].e_pcE + 32'd4 : 32'h0);
      chk($sformatf("v%0d Rs1_E", i), {27'b0, Rs1_E}, {27'b0, vecs[i].e_rs1});
      chk($sformatf("v%0d Rs2_E", i), {27'b0, Rs2_E}, {27'b0, vecs[i].e_rs2});
      chk($sformatf("v%0d Rd_E", i), {27'b0, Rd_E}, {27'b0, vecs[i].e_rd});
      chk($sformatf("v%0d Valid_E", i), {31'b0, Valid_E}, {31'b0, vecs[i].e_vE});
      chk($sformatf("v%0d Stall_Cnt", i), {28'b0, Stall_Cnt}, {28'b0, vecs[i].e_sc});
      chk($sformatf("v%0d Flush_Cnt", i), {28'b0, Flush_Cnt}, {28'b0, vecs[i].e_fc});
    end

    // PC wrap at the top of the address space
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0000_0093, 10'h0, 32'h0);
    step();
    chk("wrap redirect PC_F", PC_F, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0000_0093, 10'h0, 32'h0);
    step();
    chk("wrap PC_F", PC_F, 32'h0);
    chk("wrap PC_D", PC_D, 32'hFFFF_FFFC);
    chk("wrap PCPlus4_D", PCPlus4_D, 32'h0);
    chk("wrap Flush_Cnt", {28'b0, Flush_Cnt}, 32'd4);
    step();
    chk("pre-stall PC_F", PC_F, 32'h4);

    // Long stall: Stall_Cnt climbs from 3 and saturates at 15
    drive(1, 1, 0, 0, 0, 32'h0, 32'h0000_0513, 10'h3FF, 32'h1234_5678);
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 5)  chk("stall5 Stall_Cnt", {28'b0, Stall_Cnt}, 32'd8);
      if (c == 12) chk("stall12 Stall_Cnt", {28'b0, Stall_Cnt}, 32'd15);
    end
    chk("stall20 Stall_Cnt", {28'b0, Stall_Cnt}, 32'd15);
    chk("stall20 PC_F", PC_F, 32'h4);
    chk("stall20 Ctrl_E", {22'b0, Ctrl_E}, 32'h3FF);
    chk("stall20 Valid_D", {31'b0, Valid_D}, 32'h1);

    // Async reset mid-cycle, well away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("async PC_F", PC_F, 32'h0);
    chk("async Instr_D", Instr_D, 32'h0000_0013);
    chk("async PC_D", PC_D, 32'h0);
    chk("async Valid_D", {31'b0, Valid_D}, 32'h0);
    chk("async Ctrl_E", {22'b0, Ctrl_E}, 32'h0);
    chk("async RD1_E", RD1_E, 32'h0);
    chk("async Valid_E", {31'b0, Valid_E}, 32'h0);
    chk("async Stall_Cnt", {28'b0, Stall_Cnt}, 32'h0);
    chk("async Flush_Cnt", {28'b0, Flush_Cnt}, 32'h0);

    drive(0, 0, 0, 0, 0, 32'h0, 32'h0000_0093, 10'h0, 32'h0);
    #1 rst_n = 1'b1;
    step();
    chk("post-reset PC_F", PC_F, 32'h4);
    chk("post-reset Instr_D", Instr_D, 32'h0000_0093);
    chk("post-reset Valid_D", {31'b0, Valid_D}, 32'h1);
    chk("post-reset Stall_Cnt", {28'b0, Stall_Cnt}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
